// File: rtl/hazard_pkg.sv
// Shared constants for the D-stage hazard scoreboard: Tuse/Tnew codes,
// forwarding-select encodings and HI/LO unit latencies.
package hazard_pkg;

    localparam int TW_DEFAULT = 3;

    // All-ones Tuse marks a source port that the instruction does not read.
    localparam logic [TW_DEFAULT-1:0] TUSE_NONE = '1;

    localparam int FWD_RF    = 0;
    localparam int FWD_STAGE = 1;

    localparam int MULT_LAT_DEFAULT = 5;
    localparam int DIV_LAT_DEFAULT  = 10;

    localparam logic [TW_DEFAULT-1:0] TNEW_ALU  = 3'd1;
    localparam logic [TW_DEFAULT-1:0] TNEW_LOAD = 3'd2;
    localparam logic [TW_DEFAULT-1:0] TNEW_LUI  = 3'd1;

endpackage

// File: rtl/md_busy_counter.sv
// HI/LO busy tracker: loads the mult or div latency when a mult/div issues
// and counts down to idle.
module md_busy_counter #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic is_div,
    output logic busy
);

    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic [CW-1:0] count_q;

    // NOTE: reset is sampled on the clock edge, so it sits inside the
    // always_ff body rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (count_q != '0) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign busy = (count_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard controller: tracks in-flight producers across NSTAGE stages
// and derives the D-stage stall, per-port forwarding selects and HI/LO busy.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NSRC     = 2,
    parameter int NSTAGE   = 3,
    parameter int AW       = 5,
    parameter int TW       = 3,
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int DIV_LAT  = DIV_LAT_DEFAULT,
    localparam int SW      = $clog2(NSTAGE + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC*AW-1:0]   d_src_addr,
    input  logic [NSRC*TW-1:0]   d_tuse,
    input  logic [AW-1:0]        d_dst_addr,
    input  logic [TW-1:0]        d_tnew,
    input  logic                 d_md_start,
    input  logic                 d_md_div,
    input  logic                 d_md_use,
    output logic                 stall,
    output logic [NSRC*SW-1:0]   fwd_sel,
    output logic                 md_busy
);

    localparam logic [TW-1:0] TUSE_NONE_W = {TW{1'b1}};

    typedef struct packed {
        logic [AW-1:0] dst;
        logic [TW-1:0] tnew;
    } entry_t;

    entry_t          entry_q [NSTAGE];
    logic [NSRC-1:0] data_stall;
    logic            md_stall;

    // Stage 0 takes the D instruction (or a bubble on stall); older stages
    // shift down with Tnew saturating at zero.
    // NOTE: state is updated with non-blocking assignments so every stage
    // reads the pre-edge value of its neighbour.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NSTAGE; i++) entry_q[i] <= '0;
        end else begin
            entry_q[0] <= stall ? '0 : '{dst: d_dst_addr, tnew: d_tnew};
            for (int i = 1; i < NSTAGE; i++) begin
                entry_q[i].dst  <= entry_q[i-1].dst;
                entry_q[i].tnew <= (entry_q[i-1].tnew == '0) ? '0
                                                              : entry_q[i-1].tnew - TW'(1);
            end
        end
    end

    for (genvar k = 0; k < NSRC; k++) begin : g_port
        logic [AW-1:0]     src;
        logic [TW-1:0]     tuse;
        logic [NSTAGE-1:0] hit;
        logic              found;
        logic [TW-1:0]     y_tnew;
        logic [SW-1:0]     y_sel;

        assign src  = d_src_addr[k*AW +: AW];
        assign tuse = d_tuse[k*TW +: TW];

        for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
            assign hit[i] = (entry_q[i].dst == src) && (entry_q[i].dst != '0);
        end

        // Scan oldest to youngest so the youngest match overwrites older ones.
        // NOTE: every always_comb output gets a default first so no latch
        // is inferred when nothing matches.
        always_comb begin
            found  = 1'b0;
            y_tnew = '0;
            y_sel  = SW'(FWD_RF);
            for (int i = NSTAGE - 1; i >= 0; i--) begin
                if (hit[i]) begin
                    found  = 1'b1;
                    y_tnew = entry_q[i].tnew;
                    y_sel  = SW'(FWD_STAGE + i);
                end
            end
        end

        assign data_stall[k]          = found && (tuse != TUSE_NONE_W) && (y_tnew > tuse);
        assign fwd_sel[k*SW +: SW]    = (found && y_tnew == '0) ? y_sel : SW'(FWD_RF);
    end

    assign md_stall = d_md_use && md_busy;
    assign stall    = (|data_stall) || md_stall;

    md_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .load   (d_md_start && !stall),
        .is_div (d_md_div),
        .busy   (md_busy)
    );

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Sequential hazard controller for the MIPS pipeline. Consumes the per-instruction Tuse/Tnew codes that the decode-stage timing decoder produces.
- Tracks every in-flight producer's destination register and remaining Tnew across NSTAGE post-decode stages.
- Drives the D-stage stall and per-source forwarding selects.
- Generalises the old single-stage comparison to NSRC source ports and configurable pipeline depth. Adds a latency-counting HI/LO busy tracker for mult/div.

Parameters:
- NSRC, 2, number of D-stage source register ports (rs, rt, ...).
- NSTAGE, 3, number of tracked stages after D (index 0 = E, 1 = M, 2 = W).
- AW, 5, register address width.
- TW, 3, Tuse/Tnew field width. All-ones Tuse = TUSE_NONE (source not read).
- MULT_LAT, 5, busy cycles for mult/multu.
- DIV_LAT, 10, busy cycles for div/divu.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (reset==0 at posedge clears all state).
- d_src_addr  in  NSRC*AW  D-stage source register numbers, port k at [k*AW +: AW].
- d_tuse  in  NSRC*TW  Tuse per port; TUSE_NONE = no read.
- d_dst_addr  in  AW  D-stage destination register; 0 = no write.
- d_tnew  in  TW  D-stage Tnew counted at E entry.
- d_md_start  in  1  D instruction is mult/multu/div/divu.
- d_md_div  in  1  with d_md_start: 1 = div-class, 0 = mult-class.
- d_md_use  in  1  D instruction touches HI/LO (mfhi/mflo/mthi/mtlo/mult/div).
- stall  out  1  freeze F/D, insert bubble into E.
- fwd_sel  out  NSRC*SW  per-port D-stage select, SW = $clog2(NSTAGE+1). 0 = regfile, i+1 = stage i.
- md_busy  out  1  HI/LO unit busy.

Behaviour:
- Scoreboard: NSTAGE entries {dst[AW], tnew[TW]}.
- On each posedge with reset==1:
  - entry[i+1] <= entry[i] with tnew' = (tnew==0) ? 0 : tnew-1.
  - entry[0] <= stall ? {0,0} (bubble) : {d_dst_addr, d_tnew}.
  - The old entry[NSTAGE-1] is discarded.
- Match for port k: entry[i].dst == d_src_addr[k] and dst != 0. Only the youngest (lowest i) match counts; older matches are shadowed.
- Data stall for port k: a youngest match exists and d_tuse[k] != TUSE_NONE and entry.tnew > d_tuse[k].
- md stall: d_md_use && md_busy.
- stall = OR of all port data stalls, OR md stall. Purely combinational from current state and D inputs.
- fwd_sel[k]:
  - i+1 if the youngest match is in stage i with tnew==0.
  - Otherwise 0, covering no match, or the value is not ready yet (resolved again in a later stage).
  - Computed regardless of stall.
- md counter, width $clog2(DIV_LAT+1):
  - On posedge, if d_md_start && !stall: load MULT_LAT or DIV_LAT.
  - Else if nonzero: decrement.
  - md_busy = (counter != 0).
  - A load while busy is impossible, because the instruction stalls on d_md_use. If it is asserted anyway, the load wins.
- Reset (reset==0 at posedge):
  - All entries {0,0}, counter 0.
  - Resulting outputs: stall=0, fwd_sel=0 (given no matching D inputs), md_busy=0.
  - Reset overrides any in-progress load or shift. No partial state survives.
- Register 0 never matches and never stalls.
- Tnew saturates at 0 and never wraps.

Decomposition:
- hazard_pkg holds:
  - TUSE_NONE.
  - Fwd-select encodings (FWD_RF=0, FWD_STAGE base).
  - MULT_LAT/DIV_LAT defaults.
  - The Tnew constants (ALU=1, LOAD=2, LUI=1).
- Sub-module md_busy_counter (params MULT_LAT, DIV_LAT; ports clk, reset, load, is_div, busy).
- Scoreboard shift/match logic stays in the top module as generate loops over NSTAGE and NSRC.

Test Plan:
- Load-use: lw $8 advances (d_dst=8, tnew=2); next cycle D add with src0=8, tuse=1 -> stall=1 for 1 cycle. Following cycle (entry in M, tnew=1) -> stall=0, fwd_sel[0]=0. One cycle later (W, tnew=0) a D use gets fwd_sel[0]=3.
- ALU forward: addu $9 (tnew=1) advances; next cycle D beq src0=9, tuse=0 -> stall=1. Next cycle (M, tnew=0) -> stall=0, fwd_sel[0]=2.
- Shadowing: $10 written by stage2 (tnew 0) and stage0 (tnew 1); D src1=10, tuse=1 -> stall=0, fwd_sel[1]=0 (youngest wins, not stage 3).
- Zero register / no use: entry dst=0 with D src=0; and d_tuse=TUSE_NONE matching a tnew=2 entry -> stall=0, fwd_sel=0.
- md busy: div advances (d_md_div=1) -> md_busy=1 for exactly 10 cycles. D mflo stalls all 10 and proceeds on the 11th. Repeat with mult: 5 cycles.
- Reset mid-operation: reset=0 while the counter=7 and entries are live -> next cycle md_busy=0, stall=0 for any D input.
